// File: rtl/counter_sequencer.sv
// Command-driven sequencer for four_universal_counter: preloads the counter, enables it for a
// commanded number of cycles, tallies carry-out events and reports the final value with a done pulse.
module counter_sequencer #(
  parameter int WIDTH  = 4,
  parameter int TICK_W = 8,
  parameter int WRAP_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [WIDTH-1:0]  cmd_start,
  input  logic [TICK_W-1:0] cmd_ticks,
  input  logic              abort,
  output logic [WIDTH-1:0]  cnt_din,
  output logic              cnt_load,
  output logic              cnt_count,
  input  logic              cnt_cout,
  input  logic [WIDTH-1:0]  cnt_value,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [WIDTH-1:0]  result,
  output logic [WRAP_W-1:0] wraps
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_t;

  state_t            state;
  logic [TICK_W-1:0] tick_left;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // cnt_load / cnt_count are set on the edge entering LOAD / RUN so they are high
  // exactly for the cycles spent in those states.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      tick_left <= '0;
      cnt_din   <= '0;
      cnt_load  <= 1'b0;
      cnt_count <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      result    <= '0;
      wraps     <= '0;
    end else begin
      // NOTE: non-blocking default makes done a single-cycle pulse; only DONE overrides it.
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            cnt_din   <= cmd_start;
            tick_left <= cmd_ticks;
            wraps     <= '0;
            aborted   <= 1'b0;
            cnt_load  <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          cnt_load <= 1'b0;
          if (abort) begin
            aborted <= 1'b1;
            state   <= DONE;
          end else if (tick_left != '0) begin
            cnt_count <= 1'b1;
            state     <= RUN;
          end else begin
            state <= DONE;
          end
        end
        RUN: begin
          tick_left <= tick_left - 1'b1;
          if (cnt_cout && (wraps != '1)) wraps <= wraps + 1'b1;
          // The closing RUN cycle has already counted, even when abort arrives with it.
          if (abort || (tick_left == TICK_W'(1))) begin
            cnt_count <= 1'b0;
            aborted   <= abort;
            state     <= DONE;
          end
        end
        DONE: begin
          result <= cnt_value;
          done   <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
